// File: rtl/grayscale_wr_buffer.sv
// -----------------------------------------------------------------------------
// grayscale_wr_buffer
//   Credit-managed result FIFO between the grayscale pipeline output and the
//   c1 write path of grayscale_requestor. The pipeline cannot be stalled, so
//   each c0 read reserves one slot here before it is issued. credit_avail is
//   high only while occupancy + inflight < DEPTH. Results leave first-word-
//   fall-through through a registered head (data_out/valid_out).
//
// Ports
//   clk, reset_n        clock, async active-low reset
//   flush               synchronous clear of pointers, counters, error flags
//   rd_issue            one c0 read issued this cycle (reserves a slot)
//   credit_avail        registered: requestor may issue a read this cycle
//   data_in, valid_in   pipeline result (no backpressure)
//   data_out, valid_out registered head entry / FIFO non-empty
//   ready_in            write path accepts the head entry
//   occupancy           entries stored
//   inflight            reads issued whose results have not yet arrived
//   err_overflow        sticky: valid_in dropped because FIFO was full
//   err_protocol        sticky: rd_issue without credit, or valid_in with
//                       inflight = 0
//
// Optional build macro GRAYSCALE_WRBUF_STATS_EN adds
//   hwm                 max occupancy since reset/flush
//   drop_cnt            saturating count of dropped valid_in beats
// -----------------------------------------------------------------------------
module grayscale_wr_buffer #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 512,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              rd_issue,
  output logic              credit_avail,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CNT_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  inflight,
  output logic              err_overflow,
  output logic              err_protocol
`ifdef GRAYSCALE_WRBUF_STATS_EN
  ,
  output logic [CNT_W-1:0]  hwm,
  output logic [31:0]       drop_cnt
`endif
);

  localparam int               PTR_W   = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  occ_r;
  logic [CNT_W-1:0]  infl_r;
  logic              credit_r;
  logic              vout_r;
  logic [DATA_W-1:0] dout_r;
  logic              err_ovf_r;
  logic              err_prot_r;

  logic              pop_s;
  logic              full_s;
  logic              push_s;
  logic              drop_s;
  logic              rd_acc_s;
  logic              rd_bad_s;
  logic              infl_zero_s;
  logic              in_dec_s;
  logic [CNT_W-1:0]  occ_next_s;
  logic [CNT_W-1:0]  infl_next_s;
  logic [PTR_W-1:0]  rd_ptr_next_s;
  logic [CNT_W:0]    reserved_next_s;
  logic [DATA_W-1:0] head_next_s;

  assign pop_s       = vout_r & ready_in;
  assign full_s      = (occ_r == DEPTH_C);
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push_s      = valid_in & (~full_s | pop_s);
  assign drop_s      = valid_in & full_s & ~pop_s;
  assign rd_acc_s    = rd_issue & credit_r;
  assign rd_bad_s    = rd_issue & ~credit_r;
  assign infl_zero_s = (infl_r == {CNT_W{1'b0}});
  assign in_dec_s    = valid_in & ~infl_zero_s;

  // Next-state occupancy, inflight and read pointer.
  always_comb begin
    occ_next_s  = occ_r;
    infl_next_s = infl_r;
    case ({push_s, pop_s})
      2'b10:   occ_next_s = occ_r + CNT_W'(1);
      2'b01:   occ_next_s = occ_r - CNT_W'(1);
      default: occ_next_s = occ_r;
    endcase
    case ({rd_acc_s, in_dec_s})
      2'b10:   infl_next_s = infl_r + CNT_W'(1);
      2'b01:   infl_next_s = infl_r - CNT_W'(1);
      default: infl_next_s = infl_r;
    endcase
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    reserved_next_s = {1'b0, occ_next_s} + {1'b0, infl_next_s};
  end

  // Head entry for next cycle; a beat written into the slot that becomes the
  // head this cycle is bypassed from data_in, since memory is not yet updated.
  always_comb begin
    head_next_s = mem_r[rd_ptr_next_s];
    if (push_s && (rd_ptr_next_s == wr_ptr_r)) begin
      head_next_s = data_in;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers, counters, credit, registered head and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      occ_r      <= {CNT_W{1'b0}};
      infl_r     <= {CNT_W{1'b0}};
      credit_r   <= 1'b1;
      vout_r     <= 1'b0;
      dout_r     <= {DATA_W{1'b0}};
      err_ovf_r  <= 1'b0;
      err_prot_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      occ_r      <= {CNT_W{1'b0}};
      infl_r     <= {CNT_W{1'b0}};
      credit_r   <= 1'b1;
      vout_r     <= 1'b0;
      dout_r     <= {DATA_W{1'b0}};
      err_ovf_r  <= 1'b0;
      err_prot_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r   <= rd_ptr_next_s;
      occ_r      <= occ_next_s;
      infl_r     <= infl_next_s;
      credit_r   <= (reserved_next_s < DEPTH_W);
      vout_r     <= (occ_next_s != {CNT_W{1'b0}});
      // Hold the last head when empty so data_out never glitches.
      if (occ_next_s != {CNT_W{1'b0}}) begin
        dout_r <= head_next_s;
      end else begin
        dout_r <= dout_r;
      end
      err_ovf_r  <= err_ovf_r | drop_s;
      err_prot_r <= err_prot_r | rd_bad_s | (valid_in & infl_zero_s);
    end
  end

  assign credit_avail = credit_r;
  assign valid_out    = vout_r;
  assign data_out     = dout_r;
  assign occupancy    = occ_r;
  assign inflight     = infl_r;
  assign err_overflow = err_ovf_r;
  assign err_protocol = err_prot_r;

`ifdef GRAYSCALE_WRBUF_STATS_EN
  logic [CNT_W-1:0] hwm_r;
  logic [31:0]      drop_cnt_r;

  // High-water mark and saturating drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hwm_r      <= {CNT_W{1'b0}};
      drop_cnt_r <= 32'h0000_0000;
    end else if (flush) begin
      hwm_r      <= {CNT_W{1'b0}};
      drop_cnt_r <= 32'h0000_0000;
    end else begin
      if (occ_next_s > hwm_r) begin
        hwm_r <= occ_next_s;
      end
      if (drop_s && (drop_cnt_r != 32'hFFFF_FFFF)) begin
        drop_cnt_r <= drop_cnt_r + 32'd1;
      end
    end
  end

  assign hwm      = hwm_r;
  assign drop_cnt = drop_cnt_r;
`endif

  grayscale_wr_buffer_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk          (clk),
    .reset_n      (reset_n),
    .occupancy    (occ_r),
    .inflight     (infl_r),
    .err_protocol (err_prot_r)
  );

endmodule

// -----------------------------------------------------------------------------
// grayscale_wr_buffer_chk
//   Simulation checker: reserved slots (occupancy + inflight) never exceed
//   DEPTH while the requestor obeys the credit protocol. Once err_protocol is
//   set the upstream side has already misbehaved, so the bound is not claimed.
// Ports: clk, reset_n, occupancy, inflight, err_protocol (all inputs).
// -----------------------------------------------------------------------------
module grayscale_wr_buffer_chk #(
  parameter int DEPTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic             clk,
  input logic             reset_n,
  input logic [CNT_W-1:0] occupancy,
  input logic [CNT_W-1:0] inflight,
  input logic             err_protocol
);

  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

  a_reserved_bound : assert property (@(posedge clk) disable iff (!reset_n)
    (err_protocol || (({1'b0, occupancy} + {1'b0, inflight}) <= DEPTH_W)));

endmodule

// File: tb/tb_grayscale_wr_buffer.sv
// Self-checking bench for grayscale_wr_buffer: directed scenarios plus
// randomized traffic, checked every cycle against a queue-based model.
module tb_grayscale_wr_buffer;

  localparam int DEPTH  = 64;
  localparam int DATA_W = 512;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset_n;
  logic              flush;
  logic              rd_issue;
  logic              credit_avail;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_in;
  logic [CNT_W-1:0]  occupancy;
  logic [CNT_W-1:0]  inflight;
  logic              err_overflow;
  logic              err_protocol;
`ifdef GRAYSCALE_WRBUF_STATS_EN
  logic [CNT_W-1:0]  hwm;
  logic [31:0]       drop_cnt;
`endif

  grayscale_wr_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .rd_issue     (rd_issue),
    .credit_avail (credit_avail),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .occupancy    (occupancy),
    .inflight     (inflight),
    .err_overflow (err_overflow),
    .err_protocol (err_protocol)
`ifdef GRAYSCALE_WRBUF_STATS_EN
    ,
    .hwm          (hwm),
    .drop_cnt     (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int seq     = 0;

  // Reference model: stored entries, outstanding reads, credit flag, errors.
  logic [DATA_W-1:0] q[$];
  int  m_infl;
  bit  m_cred;
  bit  m_eo;
  bit  m_ep;
  int  m_hwm;
  longint m_drop;

  task automatic check(string tag, logic [DATA_W-1:0] got, logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] make_data(int s);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    d[31:0] = s;
    return d;
  endfunction

  task automatic model_clear();
    q.delete();
    m_infl = 0; m_cred = 1'b1; m_eo = 1'b0; m_ep = 1'b0;
    m_hwm = 0; m_drop = 0;
  endtask

  // One clock edge of the model, using the inputs currently driven.
  task automatic model_step();
    bit pop, push;
    if (flush) begin
      model_clear();
    end else begin
      pop = (q.size() > 0) && ready_in;
      if (rd_issue && !m_cred) m_ep = 1'b1;
      if (valid_in && m_infl == 0) m_ep = 1'b1;
      push = valid_in && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(data_in);
      else if (valid_in) begin
        m_eo = 1'b1;
        if (m_drop < 64'hFFFF_FFFF) m_drop++;
      end
      m_infl = m_infl + ((rd_issue && m_cred) ? 1 : 0) - ((valid_in && m_infl > 0) ? 1 : 0);
      m_cred = (q.size() + m_infl) < DEPTH;
      if (q.size() > m_hwm) m_hwm = q.size();
    end
  endtask

  task automatic compare_all();
    check("occupancy", occupancy, q.size());
    check("inflight", inflight, m_infl);
    check("credit_avail", credit_avail, m_cred);
    check("valid_out", valid_out, q.size() != 0);
    check("err_overflow", err_overflow, m_eo);
    check("err_protocol", err_protocol, m_ep);
    if (q.size() != 0) check("data_out", data_out, q[0]);
`ifdef GRAYSCALE_WRBUF_STATS_EN
    check("hwm", hwm, m_hwm);
    check("drop_cnt", drop_cnt, m_drop);
`endif
  endtask

  task automatic cycle(bit f, bit rd, bit vin, bit rdy);
    @(negedge clk);
    flush = f; rd_issue = rd; valid_in = vin; ready_in = rdy;
    data_in = make_data(seq);
    if (vin) seq++;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * DEPTH && q.size() > 0; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("drain_empty", occupancy, 0);
  endtask

  task automatic random_traffic(int n, bit allow_flush);
    bit rd, vin, rdy, f;
    for (int i = 0; i < n; i++) begin
      rd  = m_cred && ($urandom_range(0, 3) != 0);
      vin = (m_infl > 0) && ($urandom_range(0, 2) != 0);
      rdy = $urandom_range(0, 3) != 0;
      f   = allow_flush && ($urandom_range(0, 99) == 0);
      cycle(f, rd, vin, rdy);
    end
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; rd_issue = 1'b0; valid_in = 1'b0;
    ready_in = 1'b0; data_in = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_occupancy", occupancy, 0);
    check("rst_inflight", inflight, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_credit", credit_avail, 1);
    check("rst_errs", {err_overflow, err_protocol}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Credit exhaustion.
    repeat (DEPTH) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("t2_credit_zero", credit_avail, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("t2_err_protocol", err_protocol, 1);
    check("t2_inflight_64", inflight, DEPTH);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Fill with no drain, then one pop frees a credit.
    repeat (DEPTH) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (DEPTH) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_occ_full", occupancy, DEPTH);
    check("t3_inflight0", inflight, 0);
    check("t3_credit0", credit_avail, 0);
    check("t3_no_ovf", err_overflow, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_credit_back", credit_avail, 1);

    // Refill to full, then push and pop together while full.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("t4_occ_stays", occupancy, DEPTH);
    check("t4_no_drop", err_overflow, 0);
    drain();

    // Forced overflow bypassing credits.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (DEPTH + 1) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_ovf", err_overflow, 1);
    check("t5_occ", occupancy, DEPTH);
`ifdef GRAYSCALE_WRBUF_STATS_EN
    check("t5_drop_cnt", drop_cnt, 1);
    check("t5_hwm", hwm, DEPTH);
`endif
    drain();

    // Flush with traffic pending, then wrap the pointers several times.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (15) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_occ10", occupancy, 10);
    check("t6_infl5", inflight, 5);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("t6_flush_occ", occupancy, 0);
    check("t6_flush_infl", inflight, 0);
    check("t6_flush_vout", valid_out, 0);
    check("t6_flush_errs", {err_overflow, err_protocol}, 0);
    random_traffic(6 * DEPTH, 1'b0);
    drain();

    // Reset asserted in the middle of traffic.
    random_traffic(100, 1'b0);
    @(negedge clk);
    reset_n = 1'b0; rd_issue = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    model_clear();
    #1;
    check("t1_occ", occupancy, 0);
    check("t1_infl", inflight, 0);
    check("t1_vout", valid_out, 0);
    check("t1_credit", credit_avail, 1);
    check("t1_errs", {err_overflow, err_protocol}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    random_traffic(1500, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
